// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass and a pending scoreboard.
// Decode reads operands/hazards; writeback writes results and clears pending.
module reg_file_mp #(
   parameter  int WIDTH      = 32,
   parameter  int DEPTH      = 16,
   parameter  int NUM_RD     = 2,
   parameter  int NUM_WR     = 2,
   parameter  int RESET_MODE = 1,
   parameter  int ZERO_REG0  = 0,
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_pending,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic                    iss_en,
   input  logic [AW-1:0]           iss_addr,
   output logic [AW:0]             pend_cnt
);

   logic [WIDTH-1:0] mem  [DEPTH];
   logic [WIDTH-1:0] wd_r [DEPTH];
   logic [DEPTH-1:0] we_r;
   logic [DEPTH-1:0] iss_r;
   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;
   logic [AW:0]      cnt_d;
   logic [AW:0]      cnt_q;

   function automatic logic [WIDTH-1:0] rst_val(input int i);
      if (RESET_MODE == 1) return WIDTH'(i);
      else return '0;
   endfunction

   // Resolve per-register write winner (highest port) and issue hit
   always_comb begin
      we_r  = '0;
      iss_r = '0;
      for (int r = 0; r < DEPTH; r++) begin
         wd_r[r] = '0;
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
               we_r[r] = 1'b1;
               wd_r[r] = wr_data[w*WIDTH +: WIDTH];
            end
         end
         if (iss_en && iss_addr == AW'(r)) iss_r[r] = 1'b1;
      end
      if (ZERO_REG0 != 0) begin
         we_r[0]  = 1'b0;
         iss_r[0] = 1'b0;
      end
   end

   // Next pending bits (issue beats writeback) and their popcount
   always_comb begin
      pend_d = pend_q;
      cnt_d  = '0;
      for (int r = 0; r < DEPTH; r++) begin
         if (iss_r[r]) pend_d[r] = 1'b1;
         else if (we_r[r]) pend_d[r] = 1'b0;
      end
      for (int r = 0; r < DEPTH; r++) begin
         cnt_d = cnt_d + (AW+1)'(pend_d[r]);
      end
   end

   // Register storage, reset to the configured pattern
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= rst_val(i);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we_r[i]) mem[i] <= wd_r[i];
         end
      end
   end

   // Scoreboard bits and registered pending count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_cnt = cnt_q;

   // Combinational read with bypass; hazard masked when a write resolves it
   always_comb begin
      logic [AW-1:0] a;
      a          = '0;
      rd_data    = '0;
      rd_pending = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         a = rd_addr[p*AW +: AW];
         if (int'(a) < DEPTH && !(ZERO_REG0 != 0 && a == '0)) begin
            if (!rst && we_r[a]) rd_data[p*WIDTH +: WIDTH] = wd_r[a];
            else rd_data[p*WIDTH +: WIDTH] = mem[a];
            rd_pending[p] = !rst && pend_q[a] && !(we_r[a] && !iss_r[a]);
         end
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: table vectors plus hand sequences,
// expected values queued on drive and compared when outputs settle.
module tb_reg_file_mp;

   localparam int W  = 32;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [2*AW-1:0] rd_addr;
   logic [2*W-1:0]  rd_data;
   logic [2*W-1:0]  rd_data_z;
   logic [1:0]      rd_pending;
   logic [1:0]      rd_pending_z;
   logic [1:0]      wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*W-1:0]  wr_data;
   logic            iss_en;
   logic [AW-1:0]   iss_addr;
   logic [AW:0]     pend_cnt;
   logic [AW:0]     pend_cnt_z;

   typedef struct {
      string       nm;
      logic [1:0]  we;
      logic [3:0]  wa0;
      logic [31:0] wd0;
      logic [3:0]  wa1;
      logic [31:0] wd1;
      logic        ie;
      logic [3:0]  ia;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  ep;
      logic [4:0]  ec;
   } vec_t;

   typedef struct {
      string       nm;
      bit          z;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  ep;
      logic [4:0]  ec;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[14];

   reg_file_mp #(
      .WIDTH(32), .DEPTH(16), .NUM_RD(2), .NUM_WR(2),
      .RESET_MODE(1), .ZERO_REG0(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
   );

   reg_file_mp #(
      .WIDTH(32), .DEPTH(16), .NUM_RD(2), .NUM_WR(2),
      .RESET_MODE(1), .ZERO_REG0(1)
   ) u_zero (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_pending(rd_pending_z),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt_z)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input string nm, input logic [1:0] we,
      input logic [3:0] wa0, input logic [31:0] wd0,
      input logic [3:0] wa1, input logic [31:0] wd1,
      input logic ie, input logic [3:0] ia,
      input logic [3:0] ra0, input logic [3:0] ra1,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [1:0] ep, input logic [4:0] ec);
      vec_t v;
      v.nm = nm; v.we = we; v.wa0 = wa0; v.wd0 = wd0;
      v.wa1 = wa1; v.wd1 = wd1; v.ie = ie; v.ia = ia;
      v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
      v.ep = ep; v.ec = ec;
      return v;
   endfunction

   function automatic vec_t rd(
      input string nm, input logic [3:0] ra0, input logic [3:0] ra1,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [1:0] ep, input logic [4:0] ec);
      return mk(nm, 2'b00, 0, 0, 0, 0, 1'b0, 0, ra0, ra1, e0, e1, ep, ec);
   endfunction

   task automatic drive(input vec_t v);
      wr_en    = v.we;
      wr_addr  = {v.wa1, v.wa0};
      wr_data  = {v.wd1, v.wd0};
      iss_en   = v.ie;
      iss_addr = v.ia;
      rd_addr  = {v.ra1, v.ra0};
   endtask

   task automatic check_out();
      exp_t        x;
      logic [31:0] a0, a1;
      logic [1:0]  ap;
      logic [4:0]  ac;
      x = sb.pop_front();
      if (x.z) begin
         a0 = rd_data_z[31:0]; a1 = rd_data_z[63:32];
         ap = rd_pending_z; ac = pend_cnt_z;
      end else begin
         a0 = rd_data[31:0]; a1 = rd_data[63:32];
         ap = rd_pending; ac = pend_cnt;
      end
      n_vec++;
      if ({a0, a1, ap, ac} !== {x.e0, x.e1, x.ep, x.ec}) begin
         n_bad++;
         $display("FAIL %s: got d0=%h d1=%h pend=%b cnt=%0d, want d0=%h d1=%h pend=%b cnt=%0d",
                  x.nm, a0, a1, ap, ac, x.e0, x.e1, x.ep, x.ec);
      end
   endtask

   task automatic expect_now(
      input string nm, input bit z,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [1:0] ep, input logic [4:0] ec);
      exp_t x;
      x.nm = nm; x.z = z; x.e0 = e0; x.e1 = e1; x.ep = ep; x.ec = ec;
      sb.push_back(x);
      #1;
      check_out();
   endtask

   task automatic run_vec(input vec_t v, input bit z);
      @(negedge clk);
      drive(v);
      #1;
      expect_now(v.nm, z, v.e0, v.e1, v.ep, v.ec);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = rd("rd_reset", 5, 15, 5, 15, 2'b00, 0);
      tbl[1]  = mk("byp_wr3", 2'b01, 3, 32'hDEAD_BEEF, 0, 0, 1'b0, 0,
                   3, 4, 32'hDEAD_BEEF, 4, 2'b00, 0);
      tbl[2]  = rd("rd_r3", 3, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 0);
      tbl[3]  = mk("dual_wr7", 2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0,
                   7, 6, 32'h22, 6, 2'b00, 0);
      tbl[4]  = rd("rd_r7", 7, 0, 32'h22, 0, 2'b00, 0);
      tbl[5]  = mk("iss_r4", 2'b00, 0, 0, 0, 0, 1'b1, 4,
                   4, 4, 4, 4, 2'b00, 0);
      tbl[6]  = rd("pend_r4", 1, 4, 1, 4, 2'b10, 1);
      tbl[7]  = mk("wb_r4", 2'b10, 0, 0, 4, 32'h44, 1'b0, 0,
                   4, 4, 32'h44, 32'h44, 2'b00, 1);
      tbl[8]  = rd("rd_r4", 4, 9, 32'h44, 9, 2'b00, 0);
      tbl[9]  = mk("iss_wr_r9", 2'b01, 9, 32'h99, 0, 0, 1'b1, 9,
                   9, 9, 32'h99, 32'h99, 2'b00, 0);
      tbl[10] = rd("pend_r9", 9, 2, 32'h99, 2, 2'b01, 1);
      tbl[11] = mk("reiss_r9", 2'b00, 0, 0, 0, 0, 1'b1, 9,
                   9, 9, 32'h99, 32'h99, 2'b11, 1);
      tbl[12] = rd("cnt_hold", 9, 9, 32'h99, 32'h99, 2'b11, 1);
      tbl[13] = mk("iss_wr_pend", 2'b01, 9, 32'hAA, 0, 0, 1'b1, 9,
                   9, 9, 32'hAA, 32'hAA, 2'b11, 1);

      // reset state, with a write and issue held off by reset
      rst = 1'b1;
      drive(mk("rst_hold", 2'b01, 5, 32'hFFFF, 0, 0, 1'b1, 5,
               5, 15, 0, 0, 2'b00, 0));
      #3;
      expect_now("rst_state", 1'b0, 5, 15, 2'b00, 0);
      expect_now("rst_state_z", 1'b1, 5, 15, 2'b00, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(rd("idle", 5, 15, 0, 0, 2'b00, 0));
      rst = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(tbl[i], 1'b0);

      // fill the scoreboard: r9 already pending
      for (int r = 0; r < 16; r++) begin
         run_vec(mk("iss_all", 2'b00, 0, 0, 0, 0, 1'b1, 4'(r),
                    9, 9, 32'hAA, 32'hAA, 2'b11,
                    5'((r <= 9) ? r + 1 : r)), 1'b0);
      end
      run_vec(mk("iss_again", 2'b00, 0, 0, 0, 0, 1'b1, 3,
                 9, 9, 32'hAA, 32'hAA, 2'b11, 16), 1'b0);
      run_vec(rd("no_wrap", 9, 9, 32'hAA, 32'hAA, 2'b11, 16), 1'b0);
      run_vec(mk("wb_r0_r15", 2'b11, 0, 32'h100, 15, 32'h1FF, 1'b0, 0,
                 0, 15, 32'h100, 32'h1FF, 2'b00, 16), 1'b0);
      run_vec(mk("dual_wb_r5", 2'b11, 5, 32'h50, 5, 32'h51, 1'b0, 0,
                 5, 0, 32'h51, 32'h100, 2'b00, 14), 1'b0);
      run_vec(mk("iss_wr_r2", 2'b01, 2, 32'h77, 0, 0, 1'b1, 2,
                 2, 5, 32'h77, 32'h51, 2'b01, 13), 1'b0);

      // reset between edges while r2 pending, with write/issue active
      @(negedge clk);
      drive(mk("rst_mid", 2'b01, 2, 32'hBAD, 0, 0, 1'b1, 5,
               2, 15, 0, 0, 2'b00, 0));
      #1;
      rst = 1'b1;
      expect_now("rst_async", 1'b0, 2, 15, 2'b00, 0);
      expect_now("rst_async_z", 1'b1, 2, 15, 2'b00, 0);
      @(posedge clk);
      #1;
      expect_now("rst_edge", 1'b0, 2, 15, 2'b00, 0);
      @(negedge clk);
      drive(rd("idle", 2, 5, 0, 0, 2'b00, 0));
      rst = 1'b0;
      #1;
      expect_now("post_rst", 1'b0, 2, 5, 2'b00, 0);

      // hard-wired r0 on the second instance
      run_vec(mk("z_wr_iss_r0", 2'b01, 0, 32'h55, 0, 0, 1'b1, 0,
                 0, 0, 0, 0, 2'b00, 0), 1'b1);
      expect_now("wr_iss_r0_main", 1'b0, 32'h55, 32'h55, 2'b00, 0);
      run_vec(rd("z_rd_r0", 0, 0, 0, 0, 2'b00, 0), 1'b1);
      expect_now("rd_r0_main", 1'b0, 32'h55, 32'h55, 2'b11, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
